m72_irq_ctrl: RTL and testbench



---
 rtl/m72_irq_ctrl.sv | 145 ++++++++++++++
 tb/tb_m72_irq_ctrl.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/m72_irq_ctrl.sv
// Interrupt controller for the V30/zet CPU in the M72 core. It handles NUM_IRQ
// sources with edge or level triggering, masking, fixed priority and nesting.
module m72_irq_ctrl #(
  parameter int         NUM_IRQ      = 8,
  parameter logic [7:0] VEC_BASE     = 8'h20,
  parameter bit         AEOI_DEFAULT = 1'b1
) (
  input  logic               CLK_32M,
  input  logic               reset_n,
  input  logic               CS,
  input  logic               IORD,
  input  logic               IOWR,
  input  logic [1:0]         A,
  input  logic [1:0]         BYTE_SEL,
  input  logic [15:0]        DIN,
  output logic [15:0]        DOUT,
  output logic               DOUT_VALID,
  input  logic [NUM_IRQ-1:0] IRQ,
  output logic               INT_RQ,
  input  logic               INT_ACK,
  output logic [15:0]        VECTOR,
  output logic               VECTOR_VALID
);

  typedef logic [NUM_IRQ-1:0] irq_vec_t;

  localparam logic [3:0] LAST_IDX = 4'(NUM_IRQ - 1);

  function automatic logic [3:0] lowest_idx(input irq_vec_t v);
    lowest_idx = 4'd0;
    for (int i = NUM_IRQ - 1; i >= 0; i--)
      if (v[i]) lowest_idx = 4'(i);
  endfunction

  function automatic irq_vec_t lowest_oh(input irq_vec_t v);
    lowest_oh = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--)
      if (v[i]) begin
        lowest_oh    = '0;
        lowest_oh[i] = 1'b1;
      end
  endfunction

  function automatic irq_vec_t lane_merge(input irq_vec_t old, input logic [15:0] d,
                                          input logic [1:0] bs);
    for (int i = 0; i < NUM_IRQ; i++)
      lane_merge[i] = bs[i >= 8] ? d[i] : old[i];
  endfunction

  irq_vec_t   irr, isr, imr, mode, irq_d;
  logic [7:0] base, vec_q;
  logic       aeoi, enable, ack_d, ack_active, int_rq;

  irq_vec_t   pend, win_oh, ack_clr, isr_set, eoi_clr, irr_nx, isr_nx;
  logic [3:0] win, isr_top, ack_idx;
  logic       rq_cond, ack_rise, ack_ok, wr, cmd;
  logic [15:0] rd_data;

  wire unused_din = ^DIN[14:10];

  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    eoi_clr  = '0;
    wr       = CS & IOWR;
    cmd      = wr & (A == 2'd0) & BYTE_SEL[0];
    pend     = irr & ~imr;
    win      = lowest_idx(pend);
    win_oh   = lowest_oh(pend);
    isr_top  = lowest_idx(isr);
    rq_cond  = enable & (|pend) & (~|isr | (win < isr_top));
    ack_rise = INT_ACK & ~ack_d;
    ack_ok   = ack_rise & rq_cond;
    ack_idx  = ack_ok ? win : LAST_IDX;
    ack_clr  = ack_ok ? (win_oh & ~mode) : '0;
    isr_set  = (ack_ok & ~aeoi) ? win_oh : '0;

    if (cmd && DIN[15]) begin
      for (int i = 0; i < NUM_IRQ; i++)
        eoi_clr[i] = (DIN[3:0] == 4'(i));
    end else if (cmd && DIN[0]) begin
      eoi_clr = lowest_oh(isr);
    end

    // A fresh edge in the ack cycle wins over the ack's clear.
    irr_nx = (mode & IRQ) | (~mode & ((irr & ~ack_clr) | (IRQ & ~irq_d)));
    isr_nx = (isr & ~eoi_clr) | isr_set;

    unique case (A)
      2'd0:    rd_data = 16'(irr);
      2'd1:    rd_data = 16'(imr);
      2'd2:    rd_data = 16'(mode);
      default: rd_data = {6'd0, enable, aeoi, base};
    endcase
  end

  // NOTE: all state uses non-blocking assignments so every update sees pre-edge values.
  always_ff @(posedge CLK_32M or negedge reset_n) begin
    if (!reset_n) begin
      irr        <= '0;
      isr        <= '0;
      imr        <= '0;
      mode       <= '0;
      irq_d      <= '0;
      base       <= VEC_BASE;
      aeoi       <= AEOI_DEFAULT;
      enable     <= 1'b1;
      vec_q      <= 8'h00;
      ack_d      <= 1'b0;
      ack_active <= 1'b0;
      int_rq     <= 1'b0;
    end else begin
      irq_d <= IRQ;
      ack_d <= INT_ACK;
      irr   <= irr_nx;
      isr   <= isr_nx;

      if (wr && A == 2'd1) imr  <= lane_merge(imr, DIN, BYTE_SEL);
      if (wr && A == 2'd2) mode <= lane_merge(mode, DIN, BYTE_SEL);
      if (wr && A == 2'd3) begin
        if (BYTE_SEL[0]) base <= DIN[7:0];
        if (BYTE_SEL[1]) begin
          aeoi   <= DIN[8];
          enable <= DIN[9];
        end
      end

      if (ack_rise) begin
        ack_active <= 1'b1;
        vec_q      <= base + {4'h0, ack_idx};
      end else if (!INT_ACK) begin
        ack_active <= 1'b0;
      end

      int_rq <= ack_rise ? 1'b0 : rq_cond;
    end
  end

  // VECTOR_VALID stays combinational so an asynchronous reset drops it at once.
  assign VECTOR_VALID = INT_ACK & ack_active;
  assign VECTOR       = {8'h00, vec_q};
  assign INT_RQ       = int_rq;
  assign DOUT_VALID   = CS & IORD;
  assign DOUT         = DOUT_VALID ? rd_data : 16'h0000;

endmodule

// File: tb/tb_m72_irq_ctrl.sv
// Self-checking bench for m72_irq_ctrl: acknowledge vectors go through a
// scoreboard queue, register and request state is compared inline.
module tb_m72_irq_ctrl;
  logic        CLK_32M = 1'b0;
  logic        reset_n = 1'b0;
  logic        CS = 1'b0, IORD = 1'b0, IOWR = 1'b0;
  logic [1:0]  A = 2'd0, BYTE_SEL = 2'd0;
  logic [15:0] DIN = 16'h0000;
  logic [15:0] DOUT;
  logic        DOUT_VALID;
  logic [7:0]  IRQ = 8'h00;
  logic        INT_RQ;
  logic        INT_ACK = 1'b0;
  logic [15:0] VECTOR;
  logic        VECTOR_VALID;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_q[$];
  logic [15:0] rd;

  m72_irq_ctrl #(.NUM_IRQ(8), .VEC_BASE(8'h20), .AEOI_DEFAULT(1'b1)) dut (
    .CLK_32M(CLK_32M), .reset_n(reset_n), .CS(CS), .IORD(IORD), .IOWR(IOWR),
    .A(A), .BYTE_SEL(BYTE_SEL), .DIN(DIN), .DOUT(DOUT), .DOUT_VALID(DOUT_VALID),
    .IRQ(IRQ), .INT_RQ(INT_RQ), .INT_ACK(INT_ACK), .VECTOR(VECTOR),
    .VECTOR_VALID(VECTOR_VALID)
  );

  always #5 CLK_32M = ~CLK_32M;

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick();
    @(posedge CLK_32M);
    #1;
  endtask

  task automatic bus_wr(input logic [1:0] a, input logic [15:0] d, input logic [1:0] bs);
    CS = 1'b1; IOWR = 1'b1; A = a; DIN = d; BYTE_SEL = bs;
    tick();
    CS = 1'b0; IOWR = 1'b0; DIN = 16'h0000; BYTE_SEL = 2'd0;
  endtask

  task automatic bus_rd(input logic [1:0] a, output logic [15:0] d);
    CS = 1'b1; IORD = 1'b1; A = a;
    #1 d = DOUT;
    CS = 1'b0; IORD = 1'b0;
    #1;
  endtask

  task automatic pulse(input logic [7:0] m);
    IRQ = m;
    tick();
    IRQ = 8'h00;
  endtask

  // Raises INT_ACK for three cycles and compares the vector against the scoreboard.
  task automatic do_ack(input logic [15:0] exp_vec);
    int n;
    logic [15:0] want;
    exp_q.push_back(exp_vec);
    INT_ACK = 1'b1;
    tick();
    n = 1;
    while (!VECTOR_VALID && n < 8) begin
      tick();
      n++;
    end
    want = exp_q.pop_front();
    checks++;
    if (!VECTOR_VALID) begin
      errors++;
      $display("FAIL ack_timeout VECTOR_VALID never rose, want vector %h", want);
    end else if (VECTOR !== want || n != 1) begin
      errors++;
      $display("FAIL ack_vector got %h after %0d cycles, want %h after 1", VECTOR, n, want);
    end
    checks++;
    if (INT_RQ !== 1'b0) begin errors++; $display("FAIL ack_rq_drop got %b want 0", INT_RQ); end
    tick();
    tick();
    INT_ACK = 1'b0;
    #1;
    checks++;
    if (VECTOR_VALID !== 1'b0) begin errors++; $display("FAIL ack_release got %b want 0", VECTOR_VALID); end
    tick();
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) tick();
    reset_n = 1'b1;
    tick();
    checks++; if (INT_RQ !== 1'b0) begin errors++; $display("FAIL rst_int_rq got %b want 0", INT_RQ); end
    checks++; if (VECTOR !== 16'h0000) begin errors++; $display("FAIL rst_vector got %h want 0000", VECTOR); end
    checks++; if (VECTOR_VALID !== 1'b0) begin errors++; $display("FAIL rst_vvalid got %b want 0", VECTOR_VALID); end
    checks++; if (DOUT !== 16'h0000) begin errors++; $display("FAIL rst_dout got %h want 0000", DOUT); end
    checks++; if (dut.isr !== 8'h00) begin errors++; $display("FAIL rst_isr got %h want 00", dut.isr); end
    bus_rd(2'd0, rd);
    checks++; if (rd !== 16'h0000) begin errors++; $display("FAIL rst_irr got %h want 0000", rd); end
    bus_rd(2'd1, rd);
    checks++; if (rd !== 16'h0000) begin errors++; $display("FAIL rst_imr got %h want 0000", rd); end
    bus_rd(2'd2, rd);
    checks++; if (rd !== 16'h0000) begin errors++; $display("FAIL rst_mode got %h want 0000", rd); end
    CS = 1'b1; IORD = 1'b1; A = 2'd3;
    #1;
    checks++; if (DOUT_VALID !== 1'b1) begin errors++; $display("FAIL rst_dout_valid got %b want 1", DOUT_VALID); end
    checks++; if (DOUT !== 16'h0320) begin errors++; $display("FAIL rst_ctrl got %h want 0320", DOUT); end
    CS = 1'b0; IORD = 1'b0;
    #1;
  endtask

  task automatic test_single_edge();
    pulse(8'h01);
    bus_rd(2'd0, rd);
    checks++; if (rd !== 16'h0001) begin errors++; $display("FAIL edge_irr got %h want 0001", rd); end
    checks++; if (INT_RQ !== 1'b0) begin errors++; $display("FAIL edge_rq_early got %b want 0", INT_RQ); end
    tick();
    checks++; if (INT_RQ !== 1'b1) begin errors++; $display("FAIL edge_rq got %b want 1", INT_RQ); end
    do_ack(16'h0020);
    bus_rd(2'd0, rd);
    checks++; if (rd !== 16'h0000) begin errors++; $display("FAIL edge_irr_clr got %h want 0000", rd); end
    checks++; if (dut.isr !== 8'h00) begin errors++; $display("FAIL edge_isr_aeoi got %h want 00", dut.isr); end
    checks++; if (INT_RQ !== 1'b0) begin errors++; $display("FAIL edge_rq_after got %b want 0", INT_RQ); end
  endtask

  task automatic test_priority();
    pulse(8'h05);
    tick();
    do_ack(16'h0020);
    bus_rd(2'd0, rd);
    checks++; if (rd !== 16'h0004) begin errors++; $display("FAIL prio_irr got %h want 0004", rd); end
    checks++; if (INT_RQ !== 1'b1) begin errors++; $display("FAIL prio_rq got %b want 1", INT_RQ); end
    do_ack(16'h0022);
    bus_wr(2'd3, 16'h0240, 2'b11);
    pulse(8'h05);
    tick();
    do_ack(16'h0040);
    checks++; if (dut.isr !== 8'h01) begin errors++; $display("FAIL prio_isr got %h want 01", dut.isr); end
    checks++; if (INT_RQ !== 1'b0) begin errors++; $display("FAIL prio_blocked got %b want 0", INT_RQ); end
    bus_wr(2'd0, 16'h0001, 2'b01);
    checks++; if (dut.isr !== 8'h00) begin errors++; $display("FAIL prio_eoi got %h want 00", dut.isr); end
    tick();
    checks++; if (INT_RQ !== 1'b1) begin errors++; $display("FAIL prio_rq2 got %b want 1", INT_RQ); end
    do_ack(16'h0042);
    bus_wr(2'd0, 16'h0001, 2'b01);
  endtask

  task automatic test_nesting();
    bus_wr(2'd3, 16'h0220, 2'b11);
    pulse(8'h04);
    tick();
    do_ack(16'h0022);
    checks++; if (dut.isr !== 8'h04) begin errors++; $display("FAIL nest_isr2 got %h want 04", dut.isr); end
    pulse(8'h08);
    tick();
    tick();
    checks++; if (INT_RQ !== 1'b0) begin errors++; $display("FAIL nest_low_blocked got %b want 0", INT_RQ); end
    pulse(8'h01);
    tick();
    checks++; if (INT_RQ !== 1'b1) begin errors++; $display("FAIL nest_high_rq got %b want 1", INT_RQ); end
    do_ack(16'h0020);
    checks++; if (dut.isr !== 8'h05) begin errors++; $display("FAIL nest_isr05 got %h want 05", dut.isr); end
    bus_wr(2'd0, 16'h0001, 2'b01);
    checks++; if (dut.isr !== 8'h04) begin errors++; $display("FAIL nest_nseoi got %h want 04", dut.isr); end
    tick();
    checks++; if (INT_RQ !== 1'b0) begin errors++; $display("FAIL nest_still_blocked got %b want 0", INT_RQ); end
    bus_wr(2'd0, 16'h8002, 2'b01);
    checks++; if (dut.isr !== 8'h00) begin errors++; $display("FAIL nest_seoi got %h want 00", dut.isr); end
    tick();
    checks++; if (INT_RQ !== 1'b1) begin errors++; $display("FAIL nest_rq3 got %b want 1", INT_RQ); end
    do_ack(16'h0023);
    bus_wr(2'd0, 16'h800B, 2'b01);
    checks++; if (dut.isr !== 8'h08) begin errors++; $display("FAIL nest_seoi_range got %h want 08", dut.isr); end
    bus_wr(2'd0, 16'h8003, 2'b10);
    checks++; if (dut.isr !== 8'h08) begin errors++; $display("FAIL nest_seoi_lane got %h want 08", dut.isr); end
    bus_wr(2'd0, 16'h8003, 2'b01);
    checks++; if (dut.isr !== 8'h00) begin errors++; $display("FAIL nest_seoi3 got %h want 00", dut.isr); end
    bus_wr(2'd0, 16'h0001, 2'b01);
    checks++; if (dut.isr !== 8'h00) begin errors++; $display("FAIL nest_eoi_empty got %h want 00", dut.isr); end
  endtask

  task automatic test_level();
    bus_wr(2'd3, 16'h0320, 2'b11);
    bus_wr(2'd2, 16'h0002, 2'b11);
    bus_rd(2'd2, rd);
    checks++; if (rd !== 16'h0002) begin errors++; $display("FAIL lvl_mode got %h want 0002", rd); end
    IRQ = 8'h02;
    tick();
    bus_rd(2'd0, rd);
    checks++; if (rd !== 16'h0002) begin errors++; $display("FAIL lvl_irr got %h want 0002", rd); end
    tick();
    checks++; if (INT_RQ !== 1'b1) begin errors++; $display("FAIL lvl_rq got %b want 1", INT_RQ); end
    do_ack(16'h0021);
    checks++; if (INT_RQ !== 1'b1) begin errors++; $display("FAIL lvl_reassert got %b want 1", INT_RQ); end
    IRQ = 8'h00;
    tick();
    bus_rd(2'd0, rd);
    checks++; if (rd !== 16'h0000) begin errors++; $display("FAIL lvl_irr_drop got %h want 0000", rd); end
    tick();
    tick();
    checks++; if (INT_RQ !== 1'b0) begin errors++; $display("FAIL lvl_rq_drop got %b want 0", INT_RQ); end
    bus_wr(2'd2, 16'h0000, 2'b11);
  endtask

  task automatic test_mask_enable();
    bus_wr(2'd1, 16'h00FF, 2'b11);
    pulse(8'h10);
    tick();
    tick();
    checks++; if (INT_RQ !== 1'b0) begin errors++; $display("FAIL mask_rq got %b want 0", INT_RQ); end
    bus_rd(2'd0, rd);
    checks++; if (rd !== 16'h0010) begin errors++; $display("FAIL mask_irr got %h want 0010", rd); end
    bus_wr(2'd1, 16'h0000, 2'b11);
    checks++; if (INT_RQ !== 1'b0) begin errors++; $display("FAIL unmask_early got %b want 0", INT_RQ); end
    tick();
    checks++; if (INT_RQ !== 1'b1) begin errors++; $display("FAIL unmask_rq got %b want 1", INT_RQ); end
    do_ack(16'h0024);
    bus_wr(2'd3, 16'h0120, 2'b11);
    pulse(8'h20);
    tick();
    tick();
    checks++; if (INT_RQ !== 1'b0) begin errors++; $display("FAIL dis_rq got %b want 0", INT_RQ); end
    bus_rd(2'd0, rd);
    checks++; if (rd !== 16'h0020) begin errors++; $display("FAIL dis_irr got %h want 0020", rd); end
    bus_wr(2'd3, 16'h0320, 2'b11);
    tick();
    checks++; if (INT_RQ !== 1'b1) begin errors++; $display("FAIL en_rq got %b want 1", INT_RQ); end
    do_ack(16'h0025);
  endtask

  task automatic test_spurious_reset();
    int n;
    logic [15:0] want;
    bus_wr(2'd3, 16'h0220, 2'b11);
    checks++; if (INT_RQ !== 1'b0) begin errors++; $display("FAIL spur_idle got %b want 0", INT_RQ); end
    exp_q.push_back(16'h0027);
    INT_ACK = 1'b1;
    tick();
    n = 1;
    while (!VECTOR_VALID && n < 8) begin
      tick();
      n++;
    end
    want = exp_q.pop_front();
    checks++;
    if (VECTOR_VALID !== 1'b1 || VECTOR !== want) begin
      errors++;
      $display("FAIL spur_vector got %h valid %b, want %h valid 1", VECTOR, VECTOR_VALID, want);
    end
    checks++; if (dut.isr !== 8'h00) begin errors++; $display("FAIL spur_isr got %h want 00", dut.isr); end
    tick();
    reset_n = 1'b0;
    #1;
    checks++; if (VECTOR_VALID !== 1'b0) begin errors++; $display("FAIL rst_mid_vvalid got %b want 0", VECTOR_VALID); end
    checks++; if (VECTOR !== 16'h0000) begin errors++; $display("FAIL rst_mid_vector got %h want 0000", VECTOR); end
    INT_ACK = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
    bus_rd(2'd3, rd);
    checks++; if (rd !== 16'h0320) begin errors++; $display("FAIL rst_mid_ctrl got %h want 0320", rd); end
  endtask

  initial begin
    test_reset();
    test_single_edge();
    test_priority();
    test_nesting();
    test_level();
    test_mask_enable();
    test_spurious_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
